// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode patterns,
// the control bundle carried down the pipe, and ALU operation codes.
package ctrl_pkg;

    localparam int CTRL_W = 17;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    localparam logic [4:0] LINK_REG = 5'd30;

    // casez patterns on instr[31:21]
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_BL   = 11'b100101?????;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [10:0] OP_BLT  = 11'b01010100???;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    typedef enum logic [2:0] {
        BRK_NONE,
        BRK_B,
        BRK_BL,
        BRK_BR,
        BRK_BLT,
        BRK_CBZ
    } br_kind_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src;
        logic       immediate;
        logic       set_flags;
        logic       reg2loc;
        logic       blink;
        logic [2:0] alu_op;
        logic [4:0] rd;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decode: control bundle, branch kind and
// which register sources the instruction actually reads.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter logic [4:0] XZR_IDX = 5'd31
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output br_kind_t     br_kind,
    output logic         use_rn,
    output logic         use_src2,
    output logic [4:0]   rn,
    output logic [4:0]   src2
);

    ctrl_bundle_t raw;
    logic         unused_imm;

    always_comb begin
        raw      = '0;
        br_kind  = BRK_NONE;
        use_rn   = 1'b0;
        use_src2 = 1'b0;
        casez (instr[31:21])
            OP_ADDI: begin
                raw.alu_src   = 1'b1;
                raw.immediate = 1'b1;
                raw.alu_op    = ALU_ADD;
                raw.reg_write = 1'b1;
                raw.rd        = instr[4:0];
                use_rn        = 1'b1;
            end
            OP_ADDS, OP_SUBS: begin
                raw.alu_op    = (instr[30]) ? ALU_SUB : ALU_ADD;
                raw.set_flags = 1'b1;
                raw.reg_write = 1'b1;
                raw.reg2loc   = 1'b1;
                raw.rd        = instr[4:0];
                use_rn        = 1'b1;
                use_src2      = 1'b1;
            end
            OP_LDUR: begin
                raw.alu_src    = 1'b1;
                raw.mem_read   = 1'b1;
                raw.mem_to_reg = 1'b1;
                raw.reg_write  = 1'b1;
                raw.alu_op     = ALU_ADD;
                raw.rd         = instr[4:0];
                use_rn         = 1'b1;
            end
            OP_STUR: begin
                raw.alu_src   = 1'b1;
                raw.mem_write = 1'b1;
                raw.alu_op    = ALU_ADD;
                raw.rd        = instr[4:0];
                use_rn        = 1'b1;
                use_src2      = 1'b1;
            end
            OP_BL: begin
                raw.reg_write = 1'b1;
                raw.blink     = 1'b1;
                raw.rd        = LINK_REG;
                br_kind       = BRK_BL;
            end
            OP_B: begin
                raw.rd  = instr[4:0];
                br_kind = BRK_B;
            end
            OP_BR: begin
                raw.rd   = instr[4:0];
                br_kind  = BRK_BR;
                use_src2 = 1'b1;
            end
            OP_BLT: begin
                raw.rd  = instr[4:0];
                br_kind = BRK_BLT;
            end
            OP_CBZ: begin
                raw.rd   = instr[4:0];
                br_kind  = BRK_CBZ;
                use_src2 = 1'b1;
            end
            default: ;
        endcase
        bundle = raw;
        if (raw.rd == XZR_IDX) bundle.reg_write = 1'b0;
    end

    assign rn         = instr[9:5];
    assign src2       = raw.reg2loc ? instr[20:16] : instr[4:0];
    assign unused_imm = ^instr[15:10];

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage control: decode, branch resolution, load-use stall, the
// valid-qualified control pipeline and the architectural NZCV register.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int         NSTAGE   = 3,
    parameter logic [4:0] XZR_IDX  = 5'd31,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid_i,
    input  logic [31:0]              id_instr_i,
    input  logic                     cbz_zero_i,
    input  logic [3:0]               ex_nzcv_i,
    output logic                     id_ready_o,
    output logic                     br_taken_o,
    output logic                     br_uncond_o,
    output logic                     br_reg_o,
    output logic                     flush_o,
    output logic [NSTAGE-1:0]        stage_valid_o,
    output logic [NSTAGE*CTRL_W-1:0] stage_ctrl_o,
    output logic [3:0]               flags_o
);

    ctrl_bundle_t      id_bundle;
    br_kind_t          id_br;
    logic              use_rn;
    logic              use_src2;
    logic [4:0]        rn;
    logic [4:0]        src2;

    ctrl_bundle_t      ctrl_pn [NSTAGE];
    logic [NSTAGE-1:0] vld_pn;
    logic [3:0]        flags_q;

    ctrl_bundle_t      ctrl_p0;
    logic              vld_p0;
    logic              ex_setflags;
    logic [3:0]        blt_nzcv;
    logic              load_use;
    logic              id_go;

    ctrl_decode #(
        .XZR_IDX (XZR_IDX)
    ) u_decode (
        .instr    (id_instr_i),
        .bundle   (id_bundle),
        .br_kind  (id_br),
        .use_rn   (use_rn),
        .use_src2 (use_src2),
        .rn       (rn),
        .src2     (src2)
    );

    assign ctrl_p0 = ctrl_pn[0];
    assign vld_p0  = vld_pn[0];

    // BLT sees the flags the EX instruction is producing this cycle
    assign ex_setflags = vld_p0 && ctrl_p0.set_flags;
    assign blt_nzcv    = ex_setflags ? ex_nzcv_i : flags_q;

    assign load_use = vld_p0 && ctrl_p0.mem_read && (ctrl_p0.rd != XZR_IDX) &&
                      ((use_rn && (rn == ctrl_p0.rd)) ||
                       (use_src2 && (src2 == ctrl_p0.rd)));

    assign id_ready_o = !(id_valid_i && load_use);
    assign id_go      = id_valid_i && !load_use;

    always_comb begin
        br_taken_o  = 1'b0;
        br_uncond_o = 1'b0;
        br_reg_o    = 1'b0;
        if (id_go) begin
            case (id_br)
                BRK_B, BRK_BL: begin
                    br_taken_o  = 1'b1;
                    br_uncond_o = 1'b1;
                end
                BRK_BR: begin
                    br_taken_o  = 1'b1;
                    br_uncond_o = 1'b1;
                    br_reg_o    = 1'b1;
                end
                BRK_CBZ: br_taken_o = cbz_zero_i;
                BRK_BLT: br_taken_o = blt_nzcv[3] ^ blt_nzcv[0];
                default: ;
            endcase
        end
    end

    assign flush_o = br_taken_o;

    // ID -> EX and down the stages; a stall injects a clean bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pn  <= '0;
            flags_q <= FLAG_RST;
            for (int k = 0; k < NSTAGE; k++) ctrl_pn[k] <= '0;
        end else begin
            vld_pn[0]  <= id_go;
            ctrl_pn[0] <= id_go ? id_bundle : '0;
            for (int k = 1; k < NSTAGE; k++) begin
                vld_pn[k]  <= vld_pn[k-1];
                ctrl_pn[k] <= ctrl_pn[k-1];
            end
            if (ex_setflags) flags_q <= ex_nzcv_i;
        end
    end

    for (genvar g = 0; g < NSTAGE; g++) begin : g_pack
        assign stage_ctrl_o[g*CTRL_W +: CTRL_W] = ctrl_pn[g];
    end

    assign stage_valid_o = vld_pn;
    assign flags_o       = flags_q;

endmodule
